// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the prescaled counter with a sequential BCD converter.
// Holds the FSM state enum and the add-3 digit correction used by the double-dabble step.
package count_ctrl_pkg;

  localparam int unsigned BCD_W       = 12;
  localparam int unsigned DIGITS      = 3;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CONV = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Correct every digit that would overflow past 9 once doubled.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r[4*d +: 4] >= ADD3_THRESH) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter: one shift-add-3 step per cycle, WIDTH cycles per value.
// done pulses for one cycle once bcd holds the finished result.
module bin2bcd_seq
  import count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [WIDTH-1:0] bin;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] adj;
  logic [3:0]       iter;
  logic             active;

  always_comb adj = add3_adjust(acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin    <= '0;
      acc    <= '0;
      iter   <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin    <= din;
        acc    <= '0;
        iter   <= '0;
        active <= 1'b1;
      end else if (active) begin
        acc <= {adj[BCD_W-2:0], bin[WIDTH-1]};
        bin <= bin << 1;
        if (iter == 4'(WIDTH - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          iter <= iter + 4'd1;
        end
      end
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/count_bcd_ctrl.sv
// Prescaled up-counter with preload; every count change is converted to three BCD digits
// and presented on a valid/ready output before counting resumes.
module count_bcd_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] v,
  input  logic [DIV_W-1:0] div,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [BCD_W-1:0] bcd,
  output logic [WIDTH-1:0] count,
  output logic             busy
);

  if (WIDTH == 0 || WIDTH > 9) begin : g_bad_width
    $error("count_bcd_ctrl: WIDTH must be in 1..9");
  end

  state_t           state;
  logic [DIV_W-1:0] presc;
  logic             ret_run;
  logic             stop_pend;
  logic             tick;
  logic             conv_start;
  logic [WIDTH-1:0] conv_din;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  assign tick = (presc == div);

  // The converter is fed the value count is about to take, so it captures it on CONV entry.
  always_comb begin
    conv_start = 1'b0;
    conv_din   = count;
    if (!stop) begin
      if (state == IDLE && load) begin
        conv_start = 1'b1;
        conv_din   = v;
      end else if (state == RUN) begin
        if (load) begin
          conv_start = 1'b1;
          conv_din   = v;
        end else if (tick) begin
          conv_start = 1'b1;
          conv_din   = count + WIDTH'(1);
        end
      end
    end
  end

  bin2bcd_seq #(.WIDTH(WIDTH)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .din   (conv_din),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      presc     <= '0;
      ret_run   <= 1'b0;
      stop_pend <= 1'b0;
      bcd       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stop) begin
            state <= IDLE;
          end else if (load) begin
            count   <= v;
            ret_run <= 1'b0;
            state   <= CONV;
          end else if (start) begin
            presc <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (load) begin
            count   <= v;
            presc   <= '0;
            ret_run <= 1'b1;
            state   <= CONV;
          end else if (tick) begin
            count   <= count + WIDTH'(1);
            presc   <= '0;
            ret_run <= 1'b1;
            state   <= CONV;
          end else begin
            presc <= presc + DIV_W'(1);
          end
        end
        CONV: begin
          if (stop) stop_pend <= 1'b1;
          if (conv_done) begin
            bcd       <= conv_bcd;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // A stop arriving in the handshake cycle itself still forces IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            stop_pend <= 1'b0;
            state     <= (ret_run && !stop_pend && !stop) ? RUN : IDLE;
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_count_bcd_ctrl.sv
// Self-checking bench for count_bcd_ctrl: directed scenarios plus randomized load/prescale runs
// checked against arithmetic expectations (decimal digits, tick spacing, handshake latency).
module tb_count_bcd_ctrl;

  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, start, stop, load, out_ready;
  logic [W-1:0]  v;
  logic [DW-1:0] div;
  logic          out_valid, busy;
  logic [11:0]   bcd;
  logic [W-1:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_bcd_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .load      (load),
    .v         (v),
    .div       (div),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bcd       (bcd),
    .count     (count),
    .busy      (busy)
  );

  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] r;
    r[11:8] = 4'(n / 100);
    r[7:4]  = 4'((n / 10) % 10);
    r[3:0]  = 4'(n % 10);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (out_valid !== 1'b1 && cycles < 200);
  endtask

  task automatic wait_count_change(input logic [W-1:0] old, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (count === old && cycles < 200);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; out_ready = 1'b0;
    v = '0; div = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; out_ready = 1'b0;
    v = '0; div = '0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h expected 000", bcd); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_load_idle();
    int n;
    do_reset();
    v = 8'd173; load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b expected 1", busy); end
    checks++; if (count !== 8'd173) begin errors++; $display("FAIL load_count: got %0d expected 173", count); end
    wait_valid(n);
    checks++; if (n != W + 1) begin errors++; $display("FAIL load_latency: got %0d edges expected %0d", n, W + 1); end
    checks++; if (bcd !== 12'h173) begin errors++; $display("FAIL load_bcd: got %h expected 173", bcd); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_valid_fall: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_return_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    int n, exp_cnt, exp_n;
    do_reset();
    out_ready = 1'b1;
    v = 8'd255; load = 1'b1;
    step();
    load = 1'b0;
    wait_valid(n);
    step();
    checks++; if (busy !== 1'b0 || count !== 8'd255) begin errors++; $display("FAIL wrap_preload: busy %b count %0d expected 0/255", busy, count); end
    div = '0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(n);
      exp_cnt = (255 + 1 + k) % 256;
      exp_n   = (k == 0) ? (1 + W + 1) : (1 + 1 + W + 1);
      checks++; if (count !== W'(exp_cnt)) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", k, count, exp_cnt); end
      checks++; if (bcd !== to_bcd(exp_cnt)) begin errors++; $display("FAIL wrap_bcd[%0d]: got %h expected %h", k, bcd, to_bcd(exp_cnt)); end
      checks++; if (n != exp_n) begin errors++; $display("FAIL wrap_spacing[%0d]: got %0d expected %0d", k, n, exp_n); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_prescale();
    int n, exp_n;
    logic [W-1:0] prev;
    do_reset();
    out_ready = 1'b1;
    div = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      prev = count;
      wait_count_change(prev, n);
      exp_n = (k == 0) ? 4 : (4 + W + 2);
      checks++; if (n != exp_n) begin errors++; $display("FAIL prescale_spacing[%0d]: got %0d expected %0d", k, n, exp_n); end
      checks++; if (count !== prev + W'(1)) begin errors++; $display("FAIL prescale_count[%0d]: got %0d expected %0d", k, count, prev + W'(1)); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    int n;
    logic [11:0] b;
    logic [W-1:0] c;
    do_reset();
    div = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(n);
    checks++; if (n != 3 + W + 1) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", n, 3 + W + 1); end
    checks++; if (count !== 8'd1 || bcd !== 12'h001) begin errors++; $display("FAIL stall_first: count %0d bcd %h expected 1/001", count, bcd); end
    b = bcd;
    c = count;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || bcd !== b || count !== c) begin errors++; $display("FAIL stall_stable[%0d]: valid %b bcd %h count %0d expected 1/%h/%0d", i, out_valid, bcd, count, b, c); end
    end
    out_ready = 1'b1;
    step();
    wait_count_change(c, n);
    checks++; if (n != 3) begin errors++; $display("FAIL stall_prescaler: got %0d edges expected 3", n); end
    checks++; if (count !== 8'd2) begin errors++; $display("FAIL stall_next_count: got %0d expected 2", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_stop_conv();
    int n;
    logic [W-1:0] c;
    do_reset();
    div = '0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_valid(n);
    checks++; if (out_valid !== 1'b1 || bcd !== 12'h001) begin errors++; $display("FAIL stopconv_result: valid %b bcd %h expected 1/001", out_valid, bcd); end
    out_ready = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL stopconv_idle: busy %b valid %b expected 0/0", busy, out_valid); end
    c = count;
    repeat (5) step();
    checks++; if (count !== c || busy !== 1'b0) begin errors++; $display("FAIL stopconv_frozen: count %0d busy %b expected %0d/0", count, busy, c); end
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || count !== c) begin errors++; $display("FAIL stop_start_idle: busy %b count %0d expected 0/%0d", busy, count, c); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    int n;
    bit seen;
    do_reset();
    v = 8'd200; load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== '0 || bcd !== 12'h000 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_outputs: count %0d bcd %h valid %b busy %b expected all 0", count, bcd, out_valid, busy); end
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midreset_quiet: got activity expected none"); end
    v = 8'd42; load = 1'b1;
    step();
    load = 1'b0;
    wait_valid(n);
    checks++; if (n != W + 1 || bcd !== 12'h042) begin errors++; $display("FAIL midreset_reconv: edges %0d bcd %h expected %0d/042", n, bcd, W + 1); end
  endtask

  task automatic test_random();
    int n, d, stall, model;
    for (int t = 0; t < 6; t++) begin
      do_reset();
      model = int'($urandom_range(0, 255));
      d     = int'($urandom_range(0, 5));
      v = W'(model); load = 1'b1;
      step();
      load = 1'b0;
      wait_valid(n);
      checks++; if (n != W + 1 || bcd !== to_bcd(model)) begin errors++; $display("FAIL rand_load[%0d]: edges %0d bcd %h expected %0d/%h", t, n, bcd, W + 1, to_bcd(model)); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      div = DW'(d); start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        wait_count_change(count, n);
        model = (model + 1) % 256;
        checks++; if (n != d + 1 || count !== W'(model)) begin errors++; $display("FAIL rand_tick[%0d.%0d]: edges %0d count %0d expected %0d/%0d", t, k, n, count, d + 1, model); end
        wait_valid(n);
        checks++; if (n != W + 1 || bcd !== to_bcd(model)) begin errors++; $display("FAIL rand_conv[%0d.%0d]: edges %0d bcd %h expected %0d/%h", t, k, n, bcd, W + 1, to_bcd(model)); end
        stall = int'($urandom_range(0, 3));
        repeat (stall) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_idle();
    test_wrap();
    test_prescale();
    test_hold_stall();
    test_stop_conv();
    test_reset_mid_conv();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
